// File: rtl/clk_monitor.sv
// clk_monitor: measures the frequency of an asynchronous clock against a fixed
// window of sampling-clock cycles. It reports each window's edge count, a
// qualified frequency-OK flag and a sticky error that is set when qualification
// is lost.
module clk_monitor #(
  parameter int unsigned WINDOW       = 1000,
  parameter int unsigned EXPECTED     = 250,
  parameter int unsigned TOLERANCE    = 2,
  parameter int unsigned GOOD_WINDOWS = 3,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_mon_clk,
  input  logic                 i_locked_in,
  input  logic                 i_err_clr,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_count_valid,
  output logic                 o_freq_ok,
  output logic                 o_err
);

  localparam int unsigned TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned GW = $clog2(GOOD_WINDOWS + 1);

  localparam logic [TW-1:0]        TLAST    = TW'(WINDOW - 1);
  localparam logic [GW-1:0]        GOOD_MAX = GW'(GOOD_WINDOWS);
  localparam logic [CNT_WIDTH:0]   EXP_EXT  = (CNT_WIDTH + 1)'(EXPECTED);
  localparam logic [CNT_WIDTH:0]   TOL_EXT  = (CNT_WIDTH + 1)'(TOLERANCE);

  typedef enum logic [1:0] {
    StIdle,
    StWaitLock,
    StMeasure
  } state_e;

  state_e               r_state;
  logic [2:0]           r_mon_sync;
  logic [1:0]           r_lock_sync;
  logic [TW-1:0]        r_timer;
  logic [CNT_WIDTH-1:0] r_edge_cnt;
  logic [GW-1:0]        r_good;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_count_valid;
  logic                 r_freq_ok;
  logic                 r_err;

  logic                 w_mon_edge;
  logic                 w_locked;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic [CNT_WIDTH:0]   w_total_ext;
  logic [CNT_WIDTH:0]   w_dev;
  logic                 w_in_tol;
  logic                 w_measuring;
  logic                 w_win_end;
  logic                 w_lock_lost;
  logic                 w_err_set;
  logic [GW-1:0]        w_good_next;

  // Two-flop synchronizers; the third MON_CLK flop only serves edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mon_sync  <= '0;
      r_lock_sync <= '0;
    end else begin
      r_mon_sync  <= {r_mon_sync[1:0], i_mon_clk};
      r_lock_sync <= {r_lock_sync[0], i_locked_in};
    end
  end

  // Edge detect, saturating window total and unsigned deviation check.
  always_comb begin
    w_mon_edge  = r_mon_sync[1] & ~r_mon_sync[2];
    w_locked    = r_lock_sync[1];
    w_cnt_next  = (r_edge_cnt == '1) ? r_edge_cnt : r_edge_cnt + CNT_WIDTH'(w_mon_edge);
    w_total_ext = {1'b0, w_cnt_next};
    w_dev       = (w_total_ext >= EXP_EXT) ? (w_total_ext - EXP_EXT) : (EXP_EXT - w_total_ext);
    w_in_tol    = (w_dev <= TOL_EXT);
    w_measuring = (r_state == StMeasure) && i_en;
    w_win_end   = w_measuring && w_locked && (r_timer == TLAST);
    w_lock_lost = w_measuring && !w_locked;
    // Qualification is lost either by a bad window or by a lock drop.
    w_err_set   = r_freq_ok && (w_lock_lost || (w_win_end && !w_in_tol));
    w_good_next = (r_good == GOOD_MAX) ? r_good : r_good + GW'(1);
  end

  // Control FSM with registered outputs; EN low overrides every state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_timer       <= '0;
      r_edge_cnt    <= '0;
      r_good        <= '0;
      r_count       <= '0;
      r_count_valid <= 1'b0;
      r_freq_ok     <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      // Set has priority over clear.
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end

      if (!i_en) begin
        r_state    <= StIdle;
        r_timer    <= '0;
        r_edge_cnt <= '0;
        r_good     <= '0;
        r_freq_ok  <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_state <= StWaitLock;
          end
          StWaitLock: begin
            r_timer    <= '0;
            r_edge_cnt <= '0;
            if (w_locked) begin
              r_state <= StMeasure;
            end
          end
          StMeasure: begin
            if (!w_locked) begin
              // Abort the partial window without reporting it.
              r_state    <= StWaitLock;
              r_timer    <= '0;
              r_edge_cnt <= '0;
              r_good     <= '0;
              r_freq_ok  <= 1'b0;
            end else if (r_timer == TLAST) begin
              // Back-to-back windows: counter restarts with no dead cycle.
              r_timer       <= '0;
              r_edge_cnt    <= '0;
              r_count       <= w_cnt_next;
              r_count_valid <= 1'b1;
              if (w_in_tol) begin
                r_good <= w_good_next;
                if (w_good_next == GOOD_MAX) begin
                  r_freq_ok <= 1'b1;
                end
              end else begin
                r_good    <= '0;
                r_freq_ok <= 1'b0;
              end
            end else begin
              r_timer    <= r_timer + TW'(1);
              r_edge_cnt <= w_cnt_next;
            end
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  assign o_count       = r_count;
  assign o_count_valid = r_count_valid;
  assign o_freq_ok     = r_freq_ok;
  assign o_err         = r_err;

endmodule

// File: tb/tb_clk_monitor.sv
// Scoreboard bench for clk_monitor: stimulus pushes the expected per-window
// results, and a negedge monitor pops and checks them on every COUNT_VALID.
`timescale 1ns/100ps
module tb_clk_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        mon = 1'b0;
  logic        locked = 1'b1;
  logic        err_clr = 1'b0;
  logic [15:0] count;
  logic        count_valid;
  logic        freq_ok;
  logic        err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_valid = 0;
  int          last_vcyc = 0;
  int          prev_vcyc = 0;
  int          mon_half = 20;
  int          last_count = 0;

  typedef struct {
    int lo;
    int hi;
    bit ok;
    bit er;
  } exp_t;
  exp_t sb[$];

  clk_monitor #(
    .WINDOW      (1000),
    .EXPECTED    (250),
    .TOLERANCE   (2),
    .GOOD_WINDOWS(3),
    .CNT_WIDTH   (16)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_mon_clk    (mon),
    .i_locked_in  (locked),
    .i_err_clr    (err_clr),
    .o_count      (count),
    .o_count_valid(count_valid),
    .o_freq_ok    (freq_ok),
    .o_err        (err)
  );

  // CLK edges sit on half-ns points, MON_CLK edges on whole ns: never coincident.
  initial begin
    #0.5;
    forever #5 clk = ~clk;
  end

  initial forever begin
    mon = 1'b0;
    #(mon_half);
    mon = 1'b1;
    #(mon_half);
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  task automatic push(input int lo, input int hi, input bit ok, input bit er);
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    e.ok = ok;
    e.er = er;
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per COUNT_VALID pulse.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && count_valid) begin
      prev_vcyc  = last_vcyc;
      last_vcyc  = cyc;
      n_valid++;
      last_count = int'(count);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got COUNT_VALID with count=%0d, required none (t=%0t)",
                 count, $time);
      end else begin
        e = sb.pop_front();
        chk_range("window_count", int'(count), e.lo, e.hi);
        chk("window_freq_ok", int'(freq_ok), int'(e.ok));
        chk("window_err", int'(err), int'(e.er));
      end
    end
  end

  task automatic wait_valids(input int k);
    int target;
    int budget;
    target = n_valid + k;
    budget = k * 1100 + 200;
    while (n_valid < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    if (n_valid < target) begin
      n_checks++;
      n_errors++;
      $display("FAIL valid_timeout: got %0d pulses, required %0d (t=%0t)", n_valid, target, $time);
    end
  endtask

  // Change MON_CLK period, let it settle, then restart measurement via EN.
  task automatic restart(input int half);
    mon_half = half;
    repeat (20) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
  endtask

  task automatic push_qual(input bit er);
    push(249, 251, 1'b0, er);
    push(249, 251, 1'b0, er);
    push(249, 251, 1'b1, er);
  endtask

  initial begin
    int c0;
    // Reset state
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(count_valid), 0);
    chk("rst_freq_ok", int'(freq_ok), 0);
    chk("rst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Nominal 40 ns: qualify on the 3rd window and stay qualified
    push_qual(1'b0);
    push(249, 251, 1'b1, 1'b0);
    wait_valids(4);
    chk("window_period", last_vcyc - prev_vcyc, 1000);

    // 44 ns: ~227 edges, never qualifies
    restart(22);
    repeat (3) push(227, 228, 1'b0, 1'b0);
    wait_valids(3);

    // Back to 40 ns and requalify
    restart(20);
    push_qual(1'b0);
    wait_valids(3);

    // 50 ns: first (mixed) window loses qualification and sets ERR
    mon_half = 25;
    push(198, 203, 1'b0, 1'b1);
    push(199, 201, 1'b0, 1'b1);
    wait_valids(2);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", int'(err), 0);
    restart(20);
    push_qual(1'b0);
    wait_valids(3);

    // Lock drop mid-window
    repeat (300) @(negedge clk);
    locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lock_drop_freq_ok", int'(freq_ok), 0);
    chk("lock_drop_err", int'(err), 1);
    repeat (17) @(negedge clk);
    locked = 1'b1;
    c0 = cyc;
    push_qual(1'b1);
    wait_valids(1);
    chk("relock_latency", last_vcyc - c0, 1003);
    wait_valids(2);

    // EN low for 5 cycles mid-window
    repeat (400) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("en_off_freq_ok", int'(freq_ok), 0);
    chk("en_off_err", int'(err), 1);
    chk("en_off_count_hold", int'(count), last_count);
    en = 1'b1;
    c0 = cyc;
    push_qual(1'b1);
    wait_valids(1);
    chk("en_restart_latency", last_vcyc - c0, 1002);
    wait_valids(2);

    // Asynchronous reset between edges
    repeat (300) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_valid", int'(count_valid), 0);
    chk("async_rst_freq_ok", int'(freq_ok), 0);
    chk("async_rst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_qual(1'b0);
    push(249, 251, 1'b1, 1'b0);
    wait_valids(4);
    chk("window_period_after_rst", last_vcyc - prev_vcyc, 1000);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got simulation still running, required completion (t=%0t)", $time);
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
